// File: rtl/alu_result_arbiter.sv
// alu_result_arbiter: round-robin arbiter for the 8:1 ALU result mux with valid/ready hold toward writeback
// Ports: clk, rst_n (async active-low); req[7:0] pending results; out_ready consumer accept;
//        sel[2:0] mux select; grant[7:0] one-hot while out_valid; out_valid; ack[7:0] handshake pulse;
//        busy in BUSY; xfer_cnt completed handshakes (wraps).
// Option: ALU_ARB_PRIO0_EN makes requester 0 urgent and leaves the pointer untouched when 0 is served.
module alu_result_arbiter #(
  parameter logic [2:0] RR_INIT = 3'd7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic             out_ready,
  output logic [2:0]       sel,
  output logic [7:0]       grant,
  output logic             out_valid,
  output logic [7:0]       ack,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [2:0] ptr, ptr_nx, sel_nx;
  logic [7:0] mask;
  logic hs;
  // Scanning from farthest to nearest so the nearest index after p wins.
  function automatic logic [2:0] pick(input logic [7:0] m, input logic [2:0] p);
    logic [2:0] r, i;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      i = p + 3'(k + 1);
      if (m[i]) r = i;
    end
`ifdef ALU_ARB_PRIO0_EN
    if (m[0]) r = '0;
`endif
    return r;
  endfunction
  assign out_valid = state == BUSY;
  assign busy = out_valid;
  assign grant = out_valid ? 8'(1) << sel : '0;
  assign hs = out_valid & out_ready;
  assign ack = grant & {8{hs}};
  assign mask = req & ~grant;
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    ptr_nx = ptr;
    if (state == IDLE) begin
      state_nx = |req ? BUSY : IDLE;
      sel_nx = |req ? pick(req, ptr) : sel;
    end else if (out_ready) begin
`ifdef ALU_ARB_PRIO0_EN
      ptr_nx = sel == 3'd0 ? ptr : sel;
`else
      ptr_nx = sel;
`endif
      state_nx = |mask ? BUSY : IDLE;
      sel_nx = |mask ? pick(mask, ptr_nx) : sel;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      ptr <= RR_INIT;
      xfer_cnt <= '0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      ptr <= ptr_nx;
      xfer_cnt <= xfer_cnt + CNT_W'(hs);
    end
  end
endmodule

// File: tb/tb_alu_result_arbiter.sv
// tb_alu_result_arbiter: directed self-checking bench for alu_result_arbiter
module tb_alu_result_arbiter;
  logic clk = 0, rst_n = 0, out_ready = 0;
  logic [7:0] req = 0, grant, ack;
  logic [2:0] sel;
  logic out_valid, busy;
  logic [15:0] xfer_cnt;
  int tests = 0, errs = 0;
  alu_result_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .sel(sel), .grant(grant),
    .out_valid(out_valid), .ack(ack), .busy(busy), .xfer_cnt(xfer_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_sel", sel, 0);
    chk("rst_grant", grant, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", xfer_cnt, 0);
    rst_n = 1;
    req = 8'h01;
    out_ready = 1;
    cyc();
    chk("single_sel", sel, 0);
    chk("single_valid", out_valid, 1);
    chk("single_ack", ack, 8'h01);
    chk("single_grant", grant, 8'h01);
    req = 0;
    cyc();
    chk("single_idle", out_valid, 0);
    chk("single_cnt", xfer_cnt, 1);
    req = 8'hFF;
    cyc();
    for (int k = 0; k < 16; k++) begin
      chk("rr_sel", sel, (k + 1) % 8);
      chk("rr_valid", out_valid, 1);
      chk("rr_ack", ack, 8'h01 << ((k + 1) % 8));
      cyc();
    end
    req = 0;
    cyc();
    chk("rr_cnt", xfer_cnt, 18);
    chk("rr_idle", busy, 0);
    req = 8'h08;
    out_ready = 0;
    cyc();
    req = 8'h80;
    for (int k = 0; k < 5; k++) begin
      chk("hold_sel", sel, 3);
      chk("hold_valid", out_valid, 1);
      chk("hold_ack", ack, 0);
      cyc();
    end
    out_ready = 1;
    #1;
    chk("hold_ack_rel", ack, 8'h08);
    cyc();
    chk("hold_next_sel", sel, 7);
    chk("hold_next_ack", ack, 8'h80);
    req = 0;
    cyc();
    req = 8'h40;
    cyc();
    req = 0;
    cyc();
    chk("ptr6_cnt", xfer_cnt, 21);
    req = 8'h41;
    cyc();
    chk("wrap_sel0", sel, 0);
    cyc();
    chk("wrap_sel6", sel, 6);
    chk("wrap_valid", out_valid, 1);
    cyc();
    chk("wrap_sel0b", sel, 0);
    req = 0;
    cyc();
    chk("wrap_cnt", xfer_cnt, 24);
    req = 8'h20;
    out_ready = 0;
    cyc();
    chk("mid_busy", busy, 1);
    chk("mid_sel", sel, 5);
    rst_n = 0;
    #1;
    chk("arst_sel", sel, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ack", ack, 0);
    chk("arst_cnt", xfer_cnt, 0);
    #2 rst_n = 1;
    out_ready = 1;
    cyc();
    chk("post_rst_sel", sel, 5);
    chk("post_rst_ack", ack, 8'h20);
    req = 0;
    cyc();
    chk("post_rst_cnt", xfer_cnt, 1);
    req = 8'hFF;
    cyc();
    repeat (65535) cyc();
    chk("cnt_wrap", xfer_cnt, 0);
    req = 0;
    cyc();
    chk("cnt_after_wrap", xfer_cnt, 1);
`ifdef ALU_ARB_PRIO0_EN
    req = 8'h11;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("prio_sel", sel, k[0] ? 4 : 0);
      cyc();
    end
    req = 0;
    cyc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
